servant_rst_gen: RTL and testbench
==================================

SERVANT_RST_GEN -- requirements
Module: servant_rst_gen

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for i_locked; legal values 2..4.
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release; legal values 1..65536.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: additional cycles o_rst is held after lock qualification; legal values 1..65536.
REQ-004 SHALL have port i_clk  input  1  PLL output clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_locked  input  1  PLL lock indicator; asynchronous to i_clk and may glitch.
REQ-007 SHALL have port o_rst  output  1  active-high system reset for the SoC, registered.
REQ-008 SHALL have port o_ready  output  1  high exactly when the FSM is in RUN (equal to ~o_rst).
REQ-009 SHALL have port o_loss_cnt  output  8  count of lock-loss events (see Configuration).

Function
REQ-010 SHALL synchronize i_locked through a SYNC_STAGES-deep flop chain to produce locked_s; no other logic samples i_locked.
REQ-011 SHALL implement FSM states WAIT_LOCK, QUALIFY, HOLD, RUN, with a single shared 16-bit down/up counter cnt.
REQ-012 WAIT_LOCK: cnt=0; locked_s=1 -> QUALIFY.
REQ-013 QUALIFY: cnt increments each cycle with locked_s=1; at cnt==LOCK_CYCLES-1 -> HOLD with cnt cleared; locked_s=0 at any point -> WAIT_LOCK with cnt cleared.
REQ-014 HOLD: cnt increments; at cnt==HOLD_CYCLES-1 -> RUN; locked_s=0 -> WAIT_LOCK.
REQ-015 RUN: stays while locked_s=1; locked_s=0 -> WAIT_LOCK.
REQ-016 o_rst SHALL be a register: 1 in every state except RUN, updated on the same edge as the state register.
REQ-017 With i_locked held high from edge 0, o_rst SHALL fall exactly SYNC_STAGES+LOCK_CYCLES+HOLD_CYCLES+1 rising edges after edge 0.
REQ-018 On lock loss in RUN, o_rst SHALL rise no later than SYNC_STAGES+1 edges after i_locked falls.
REQ-019 A lock glitch shorter than one clock that is captured restarts qualification from WAIT_LOCK; no partial credit is retained.
REQ-020 The counter SHALL never wrap; comparisons use the full 16-bit width with parameters reduced by one.

Reset
REQ-021 i_rst_n=0 SHALL asynchronously force: synchronizer flops 0, state WAIT_LOCK, cnt 0, o_rst 1, o_ready 0, o_loss_cnt 0.
REQ-022 Reset release SHALL be synchronous in effect: first FSM evaluation occurs on the first rising edge after i_rst_n=1; reset asserted mid-QUALIFY/HOLD/RUN discards all progress.

Configuration
REQ-023 Macro RSTGEN_LOSS_CNT_EN defined: o_loss_cnt increments by 1 on every RUN->WAIT_LOCK transition, saturates at 255, and clears only on i_rst_n.
REQ-024 Macro RSTGEN_LOSS_CNT_EN undefined: no counter logic is built; o_loss_cnt is tied to 8'd0.

Verification (SYNC_STAGES=2, LOCK_CYCLES=8, HOLD_CYCLES=4 unless noted)
REQ-025 Release i_rst_n, i_locked=1 from edge 0 -> o_rst=1 through edge 14, o_rst=0 and o_ready=1 after edge 15.
REQ-026 i_locked high for 5 cycles, low 1 cycle, then high -> o_rst stays 1; release occurs 15 edges after the second rise.
REQ-027 In RUN, drop i_locked at edge N -> o_rst=1 by edge N+3; with macro, o_loss_cnt 0->1.
REQ-028 In HOLD (edge 12), assert i_rst_n=0 mid-cycle -> o_rst=1 immediately without a clock edge; after release the full 15-edge sequence repeats.
REQ-029 With macro, 300 RUN->loss cycles -> o_loss_cnt=255 (saturated); without macro -> o_loss_cnt=0 throughout.
REQ-030 Defaults (2/1024/16) with i_locked stable -> o_rst falls exactly 1043 edges after i_locked rises.

Source files
------------

// File: rtl/servant_rst_gen.sv
// PLL-lock qualified reset generator: synchronizes i_locked, qualifies it for LOCK_CYCLES, holds HOLD_CYCLES more, then releases o_rst.
// Optional lock-loss event counter is built only when RSTGEN_LOSS_CNT_EN is defined.
module servant_rst_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_locked,
    output logic       o_rst,
    output logic       o_ready,
    output logic [7:0] o_loss_cnt
);

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        QUALIFY   = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] locked_p;
    logic                   locked_s;
    state_t                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   rst_q, rst_d;

    // Synchronizer stage boundary: i_locked is sampled nowhere else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            locked_p <= '0;
        end else begin
            locked_p <= {locked_p[SYNC_STAGES-2:0], i_locked};
        end
    end

    assign locked_s = locked_p[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) state_d = QUALIFY;
            end
            QUALIFY: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        // o_rst is registered from the next state so it changes on the same edge as the FSM
        rst_d = (state_d != RUN);
    end

    assign o_rst   = rst_q;
    assign o_ready = ~rst_q;

`ifdef RSTGEN_LOSS_CNT_EN
    logic [7:0] loss_q;
    logic       loss_evt;

    assign loss_evt = (state_q == RUN) && !locked_s;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            loss_q <= 8'd0;
        end else if (loss_evt && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign o_loss_cnt = loss_q;
`else
    assign o_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_servant_rst_gen.sv
// Directed bench for servant_rst_gen: small instance (2/8/4) plus a default-parameter instance.
module tb_servant_rst_gen;

`ifdef RSTGEN_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       rst_o;
    logic       ready_o;
    logic [7:0] loss_o;

    logic       rst_n2;
    logic       locked2;
    logic       rst_o2;
    logic       ready_o2;
    logic [7:0] loss_o2;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    servant_rst_gen #(
        .SYNC_STAGES(2),
        .LOCK_CYCLES(8),
        .HOLD_CYCLES(4)
    ) u_dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_locked  (locked),
        .o_rst     (rst_o),
        .o_ready   (ready_o),
        .o_loss_cnt(loss_o)
    );

    servant_rst_gen u_def (
        .i_clk     (clk),
        .i_rst_n   (rst_n2),
        .i_locked  (locked2),
        .o_rst     (rst_o2),
        .o_ready   (ready_o2),
        .o_loss_cnt(loss_o2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_loss;

        rst_n   = 1'b0;
        locked  = 1'b0;
        rst_n2  = 1'b0;
        locked2 = 1'b0;
        tick(2);
        chk("reset_rst",   {7'd0, rst_o},   8'd1);
        chk("reset_ready", {7'd0, ready_o}, 8'd0);
        chk("reset_loss",  loss_o,          8'd0);
        chk("reset_rst_def", {7'd0, rst_o2}, 8'd1);

        // Power-up: lock high from edge 0, release on the 15th edge
        rst_n  = 1'b1;
        locked = 1'b1;
        tick(14);
        chk("pwrup_e14_rst", {7'd0, rst_o}, 8'd1);
        tick(1);
        chk("pwrup_e15_rst",   {7'd0, rst_o},   8'd0);
        chk("pwrup_e15_ready", {7'd0, ready_o}, 8'd1);

        // Lock loss in RUN: reset reasserted within SYNC_STAGES+1 edges
        locked = 1'b0;
        tick(2);
        chk("loss_e2_rst", {7'd0, rst_o}, 8'd0);
        tick(1);
        chk("loss_e3_rst",   {7'd0, rst_o},   8'd1);
        chk("loss_e3_ready", {7'd0, ready_o}, 8'd0);
        exp_loss = LOSS_EN ? 8'd1 : 8'd0;
        chk("loss_cnt_1", loss_o, exp_loss);

        // Glitch during qualification: 5 high, 1 low, then high again
        locked = 1'b1;
        tick(5);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(10);
        chk("glitch_e10_rst", {7'd0, rst_o}, 8'd1);
        tick(4);
        chk("glitch_e14_rst", {7'd0, rst_o}, 8'd1);
        tick(1);
        chk("glitch_e15_rst", {7'd0, rst_o}, 8'd0);

        // Second loss, then async reset while in HOLD
        locked = 1'b0;
        tick(3);
        chk("loss2_rst", {7'd0, rst_o}, 8'd1);
        exp_loss = LOSS_EN ? 8'd2 : 8'd0;
        chk("loss_cnt_2", loss_o, exp_loss);
        locked = 1'b1;
        tick(12);
        chk("hold_e12_rst", {7'd0, rst_o}, 8'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("hold_arst_rst",  {7'd0, rst_o},   8'd1);
        chk("hold_arst_loss", loss_o,          8'd0);
        #1;
        rst_n = 1'b1;
        tick(14);
        chk("hold_rep_e14_rst", {7'd0, rst_o}, 8'd1);
        tick(1);
        chk("hold_rep_e15_rst", {7'd0, rst_o}, 8'd0);

        // Async reset while in RUN drives o_rst high with no clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("run_arst_rst",   {7'd0, rst_o},   8'd1);
        chk("run_arst_ready", {7'd0, ready_o}, 8'd0);
        #1;
        rst_n = 1'b1;
        tick(14);
        chk("run_rep_e14_rst", {7'd0, rst_o}, 8'd1);
        tick(1);
        chk("run_rep_e15_rst", {7'd0, rst_o}, 8'd0);

        // 300 loss/relock cycles: counter saturates at 255 when built
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            tick(3);
            chk("sat_loss_rst", {7'd0, rst_o}, 8'd1);
            exp_loss = LOSS_EN ? ((i >= 254) ? 8'd255 : 8'(i + 1)) : 8'd0;
            chk("sat_loss_cnt", loss_o, exp_loss);
            locked = 1'b1;
            tick(15);
            chk("sat_relock_rst", {7'd0, rst_o}, 8'd0);
        end
        exp_loss = LOSS_EN ? 8'd255 : 8'd0;
        chk("sat_final_cnt", loss_o, exp_loss);

        // Default parameters: release exactly 1043 edges after lock rises
        rst_n2  = 1'b1;
        locked2 = 1'b1;
        tick(1042);
        chk("def_e1042_rst", {7'd0, rst_o2}, 8'd1);
        tick(1);
        chk("def_e1043_rst",   {7'd0, rst_o2},   8'd0);
        chk("def_e1043_ready", {7'd0, ready_o2}, 8'd1);
        chk("def_loss",        loss_o2,          8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
